// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM state encoding and port-index type
package ram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef logic port_t;
  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two client request ports plus the single RAM bus
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic req0, req1, we0, we1, ack0, ack1, busy, ram_cs, ram_we, ram_oe;
  logic [ADDR_WIDTH-1:0] addr0, addr1, ram_address;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, rdata0, rdata1, ram_data_in, ram_data_out;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    output ack0, ack1, rdata0, rdata1, busy, ram_address, ram_cs, ram_we, ram_oe, ram_data_in
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    input  ack0, ack1, rdata0, rdata1, busy, ram_address, ram_cs, ram_we, ram_oe, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, the port not granted last wins a tie
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  port_t      last,
  output logic [1:0] gnt
);
  // one-hot grant; a lone request wins regardless of the pointer
  always_comb gnt = (req0 && req1) ? ((last == PORT0) ? 2'b10 : 2'b01) : {req1, req0};
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one asynchronous RAM between two ports
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  state_t state_q, state_d;
  port_t last_q, last_d, win_q, win_d, pick;
  logic wr_q, wr_d, start;
  logic ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
  logic cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0] gnt;
  rr_arbiter2 u_rr (.req0(bus.req0), .req1(bus.req1), .last(last_q), .gnt(gnt));
  assign pick = gnt[1] ? PORT1 : PORT0;
  // state register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      win_q    <= PORT0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  // IDLE waits for any request; ACCESS and RESP each last one cycle
  always_comb begin
    state_d = (state_q == IDLE) ? ((bus.req0 || bus.req1) ? ACCESS : IDLE) :
              (state_q == ACCESS) ? RESP : IDLE;
  end
  // latch the winner on grant, strobe the RAM for ACCESS only, ack and capture in RESP
  always_comb begin
    start    = (state_q == IDLE) && (state_d == ACCESS);
    last_d   = start ? pick : last_q;
    win_d    = start ? pick : win_q;
    wr_d     = start ? ((pick == PORT1) ? bus.we1 : bus.we0) : wr_q;
    addr_d   = start ? ((pick == PORT1) ? bus.addr1 : bus.addr0) : addr_q;
    din_d    = start ? ((pick == PORT1) ? bus.wdata1 : bus.wdata0) : din_q;
    cs_d     = start;
    we_d     = start && wr_d;
    oe_d     = start && !wr_d;
    ack0_d   = (state_q == ACCESS) && (win_q == PORT0);
    ack1_d   = (state_q == ACCESS) && (win_q == PORT1);
    rdata0_d = (ack0_d && !wr_q) ? bus.ram_data_out : rdata0_q;
    rdata1_d = (ack1_d && !wr_q) ? bus.ram_data_out : rdata1_q;
    busy_d   = state_d != IDLE;
  end
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.busy        = busy_q;
  assign bus.ram_cs      = cs_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_oe      = oe_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = din_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench with a transaction-level reference model
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  bit [7:0] ram [256];
  bit [7:0] exp_mem [256];
  logic ref_last;
  logic [7:0] ref_rd0, ref_rd1;
  int vectors = 0;
  int miscompares = 0;
  always @(posedge clk) if (bus.ram_cs && bus.ram_we) ram[bus.ram_address] <= bus.ram_data_in;
  assign bus.ram_data_out = (bus.ram_cs && bus.ram_oe && !bus.ram_we) ? ram[bus.ram_address] : 8'h00;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pair_txn(input logic r0, r1, w0, w1, input logic [7:0] a0, a1, d0, d1, input bit scramble);
    int t0, t1;
    logic first;
    logic [7:0] e0, e1;
    t0 = 0; t1 = 0; e0 = 8'h00; e1 = 8'h00;
    first = (r0 && r1) ? ~ref_last : r1;
    for (int n = 0; n < 2; n++) begin
      logic p;
      p = first ^ n[0];
      if (p ? r1 : r0) begin
        if (p) begin
          t1 = 2 + 3 * n;
          if (w1) exp_mem[a1] = d1; else e1 = exp_mem[a1];
        end else begin
          t0 = 2 + 3 * n;
          if (w0) exp_mem[a0] = d0; else e0 = exp_mem[a0];
        end
        ref_last = p;
      end
    end
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (scramble && k == 1) begin
        if (first) begin bus.we1 = ~bus.we1; bus.addr1 = 8'($urandom); bus.wdata1 = 8'($urandom); end
        else begin bus.we0 = ~bus.we0; bus.addr0 = 8'($urandom); bus.wdata0 = 8'($urandom); end
      end
      if (k == t0 && !w0) ref_rd0 = e0;
      if (k == t1 && !w1) ref_rd1 = e1;
      vectors++;
      if ({bus.ack1, bus.ack0} !== {k == t1, k == t0}) begin
        miscompares++;
        $display("FAIL ack_seq cycle %0d: ack1/ack0 got %b%b, expected %b%b", k, bus.ack1, bus.ack0, k == t1, k == t0);
      end
      vectors++;
      if ({bus.rdata1, bus.rdata0} !== {ref_rd1, ref_rd0}) begin
        miscompares++;
        $display("FAIL rdata cycle %0d: got %h/%h, expected %h/%h", k, bus.rdata1, bus.rdata0, ref_rd1, ref_rd0);
      end
      if (k == t0) bus.req0 = 1'b0;
      if (k == t1) bus.req1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    repeat (3) step();
    vectors++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.ram_cs, bus.ram_we, bus.ram_oe} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b, expected 000000", bus.ack0, bus.ack1, bus.busy, bus.ram_cs, bus.ram_we, bus.ram_oe);
    end
    vectors++;
    if ({bus.ram_address, bus.ram_data_in} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_bus: got %h/%h, expected 00/00", bus.ram_address, bus.ram_data_in);
    end
    vectors++;
    if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h, expected 00/00", bus.rdata0, bus.rdata1);
    end
    rst = 1'b0;
    ref_last = 1'b1; ref_rd0 = 8'h00; ref_rd1 = 8'h00;
  endtask

  task automatic test_contention();
    pair_txn(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0);
    pair_txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0);
    vectors++;
    if ({bus.rdata0, bus.rdata1} !== 16'h1122) begin
      miscompares++;
      $display("FAIL contention_data: got %h/%h, expected 11/22", bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_write_read();
    pair_txn(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00, 1'b0);
    pair_txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    vectors++;
    if (bus.rdata0 !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_read: rdata0 got %h, expected a5", bus.rdata0);
    end
  endtask

  task automatic test_bus_stability();
    logic [7:0] a, d;
    a = 8'($urandom_range(64, 127));
    d = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      logic w;
      w = (i == 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      step();
      vectors++;
      if ({bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy} !== {1'b1, w, ~w, 1'b1} || bus.ram_address !== a || bus.ram_data_in !== d) begin
        miscompares++;
        $display("FAIL bus_access we=%b: cs/we/oe/busy %b%b%b%b addr %h din %h, expected %b%b%b1 %h %h",
                 w, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy, bus.ram_address, bus.ram_data_in, 1'b1, w, ~w, a, d);
      end
      bus.addr1 = ~a; bus.wdata1 = ~d; bus.we1 = ~w;
      step();
      vectors++;
      if ({bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy, bus.ack1, bus.ack0} !== 6'b000110 || bus.ram_address !== a || bus.ram_data_in !== d) begin
        miscompares++;
        $display("FAIL bus_resp we=%b: cs/we/oe/busy/ack1/ack0 %b%b%b%b%b%b addr %h din %h, expected 000110 %h %h",
                 w, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy, bus.ack1, bus.ack0, bus.ram_address, bus.ram_data_in, a, d);
      end
      if (!w) begin
        vectors++;
        if (bus.rdata1 !== d) begin
          miscompares++;
          $display("FAIL bus_readback: rdata1 got %h, expected %h", bus.rdata1, d);
        end
        ref_rd1 = d;
      end
      bus.req1 = 1'b0;
      step();
      vectors++;
      if ({bus.ram_cs, bus.busy, bus.ack1} !== 3'b000) begin
        miscompares++;
        $display("FAIL bus_idle: cs/busy/ack1 got %b%b%b, expected 000", bus.ram_cs, bus.busy, bus.ack1);
      end
    end
    exp_mem[a] = d;
    ref_last = 1'b1;
  endtask

  task automatic test_sustained();
    logic first;
    first = ~ref_last;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h01; bus.addr1 = 8'h02;
    for (int k = 1; k <= 18; k++) begin
      logic [1:0] expa;
      logic p;
      int n;
      expa = 2'b00;
      step();
      if (k % 3 == 2) begin
        n = (k - 2) / 3;
        p = first ^ n[0];
        expa[p] = 1'b1;
        ref_last = p;
        if (p) ref_rd1 = exp_mem[8'h02]; else ref_rd0 = exp_mem[8'h01];
      end
      vectors++;
      if ({bus.ack1, bus.ack0} !== expa) begin
        miscompares++;
        $display("FAIL sustained cycle %0d: ack1/ack0 got %b%b, expected %b", k, bus.ack1, bus.ack0, expa);
      end
      vectors++;
      if ({bus.rdata1, bus.rdata0} !== {ref_rd1, ref_rd0}) begin
        miscompares++;
        $display("FAIL sustained_rdata cycle %0d: got %h/%h, expected %h/%h", k, bus.rdata1, bus.rdata0, ref_rd1, ref_rd0);
      end
      if (k == 17) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic r0, r1, w0, w1;
      logic [7:0] a0, a1, d0, d1;
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom_range(32, 47)); a1 = 8'($urandom_range(32, 47));
      d0 = 8'($urandom); d1 = 8'($urandom);
      pair_txn(r0, r1, w0, w1, a0, a1, d0, d1, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    pair_txn(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h00, 8'h00, 1'b0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
    step();
    vectors++;
    if (bus.ram_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_access: ram_cs got %b, expected 1", bus.ram_cs);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({bus.ack1, bus.ack0, bus.ram_cs, bus.busy} !== 4'b0000 || bus.rdata1 !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_abort: ack1/ack0/cs/busy %b%b%b%b rdata1 %h, expected 0000 00", bus.ack1, bus.ack0, bus.ram_cs, bus.busy, bus.rdata1);
    end
    rst = 1'b0; bus.req1 = 1'b0;
    ref_last = 1'b1; ref_rd0 = 8'h00; ref_rd1 = 8'h00;
    pair_txn(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h30, 8'h00, 8'h5A, 1'b0);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_bus_stability();
    test_sustained();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
